// File: rtl/ps2_key_event_queue.sv
// PS/2 scan-code set 2 decoder feeding a show-ahead key-event FIFO.
// Tracks live Shift/Ctrl/Alt state, optionally filters typematic repeats.
module ps2_key_event_queue #(
  parameter int unsigned DEPTH         = 8,
  parameter bit          REPORT_BREAK  = 1'b1,
  parameter bit          REPEAT_FILTER = 1'b0,
  localparam int unsigned ADDR_W       = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [7:0]        i_byte_data,
  input  logic              i_byte_valid,
  output logic [8:0]        o_event_key,
  output logic              o_event_break,
  output logic              o_event_valid,
  input  logic              i_event_ready,
  output logic [2:0]        o_modifiers,
  output logic              o_overflow,
  input  logic              i_clear_overflow,
  output logic [ADDR_W:0]   o_count
);

  typedef enum logic [2:0] {StIdle, StExt, StBrk, StExtBrk, StPause} state_e;

  localparam logic [ADDR_W:0] FullCount = (ADDR_W + 1)'(DEPTH);
  localparam logic [8:0] ModCodes [6] = '{9'h012, 9'h059, 9'h014, 9'h114, 9'h011, 9'h111};

  state_e            r_state, w_state_nxt;
  logic [2:0]        r_skip, w_skip_nxt;
  logic              w_dec_valid, w_dec_brk, w_dec_pause;
  logic [8:0]        w_dec_key;
  logic              w_evt, w_rep_hit, w_push, w_pop, w_full, w_wr;
  logic [5:0]        r_mod_flags;
  logic [8:0]        r_last_key;
  logic              r_last_valid;
  logic [9:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [ADDR_W:0]   r_count, w_count_nxt;
  logic              r_overflow;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_skip  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_skip  <= w_skip_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_skip_nxt  = r_skip;
    if (i_byte_valid) begin
      if (r_state == StPause) begin
        // Pause is E1 followed by seven bytes carrying no further event
        if (r_skip == 3'd6) begin
          w_state_nxt = StIdle;
          w_skip_nxt  = '0;
        end else begin
          w_skip_nxt = r_skip + 3'd1;
        end
      end else begin
        case (i_byte_data)
          8'hE0: w_state_nxt = StExt;
          8'hF0: begin
            if (r_state == StIdle)     w_state_nxt = StBrk;
            else if (r_state == StExt) w_state_nxt = StExtBrk;
          end
          8'hE1: begin
            w_state_nxt = StPause;
            w_skip_nxt  = '0;
          end
          default: w_state_nxt = StIdle;
        endcase
      end
    end
  end

  always_comb begin
    w_dec_valid = 1'b0;
    w_dec_key   = '0;
    w_dec_brk   = 1'b0;
    w_dec_pause = 1'b0;
    if (i_byte_valid && r_state != StPause) begin
      case (i_byte_data)
        8'hE0, 8'hF0, 8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hFE, 8'hEE: ;
        8'hE1: begin
          w_dec_valid = 1'b1;
          w_dec_key   = 9'h1E1;
          w_dec_pause = 1'b1;
        end
        default: begin
          w_dec_valid = 1'b1;
          w_dec_key   = {(r_state == StExt) || (r_state == StExtBrk), i_byte_data};
          w_dec_brk   = (r_state == StBrk) || (r_state == StExtBrk);
        end
      endcase
    end
  end

  assign w_evt     = w_dec_valid && (w_dec_key != 9'h112) && (w_dec_key != 9'h159);
  assign w_rep_hit = REPEAT_FILTER && r_last_valid && !w_dec_brk && !w_dec_pause &&
                     (w_dec_key == r_last_key);
  assign w_push    = w_evt && !w_rep_hit && (!w_dec_brk || REPORT_BREAK);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mod_flags  <= '0;
      r_last_key   <= '0;
      r_last_valid <= 1'b0;
    end else if (w_evt) begin
      for (int i = 0; i < 6; i++) begin
        if (w_dec_key == ModCodes[i]) r_mod_flags[i] <= !w_dec_brk;
      end
      if (!w_dec_brk) begin
        r_last_key   <= w_dec_key;
        r_last_valid <= 1'b1;
      end else if (w_dec_key == r_last_key) begin
        r_last_valid <= 1'b0;
      end
    end
  end

  assign o_modifiers = {r_mod_flags[4] | r_mod_flags[5], r_mod_flags[2] | r_mod_flags[3],
                        r_mod_flags[0] | r_mod_flags[1]};

  assign w_pop  = (r_count != '0) && i_event_ready;
  assign w_full = (r_count == FullCount);
  // A full queue still accepts a push when the head leaves in the same cycle
  assign w_wr   = w_push && (!w_full || w_pop);

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr && !w_pop)      w_count_nxt = r_count + (ADDR_W + 1)'(1);
    else if (!w_wr && w_pop) w_count_nxt = r_count - (ADDR_W + 1)'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= {w_dec_brk, w_dec_key};
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
      else if (i_clear_overflow)      r_overflow <= 1'b0;
    end
  end

  assign o_event_key   = r_mem[r_rd_ptr][8:0];
  assign o_event_break = r_mem[r_rd_ptr][9];
  assign o_event_valid = (r_count != '0);
  assign o_overflow    = r_overflow;
  assign o_count       = r_count;

endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Drives three differently configured decoders with one byte stream and checks each
// against a byte-level behavioural model with a simple circular event list.
module tb_ps2_key_event_queue;

  logic       clk = 1'b0;
  logic       rst, bv, clr;
  logic [7:0] bd;
  logic [2:0] rdy;
  logic [8:0] key  [3];
  logic       brk  [3];
  logic       ev   [3];
  logic       ovf  [3];
  logic [2:0] mods [3];
  logic [3:0] cnt_a, cnt_c;
  logic [2:0] cnt_b;

  always #5 clk = ~clk;

  ps2_key_event_queue #(.DEPTH(8), .REPORT_BREAK(1'b1), .REPEAT_FILTER(1'b0)) u_a (
    .i_clk(clk), .i_rst(rst), .i_byte_data(bd), .i_byte_valid(bv),
    .o_event_key(key[0]), .o_event_break(brk[0]), .o_event_valid(ev[0]),
    .i_event_ready(rdy[0]), .o_modifiers(mods[0]), .o_overflow(ovf[0]),
    .i_clear_overflow(clr), .o_count(cnt_a));

  ps2_key_event_queue #(.DEPTH(4), .REPORT_BREAK(1'b1), .REPEAT_FILTER(1'b1)) u_b (
    .i_clk(clk), .i_rst(rst), .i_byte_data(bd), .i_byte_valid(bv),
    .o_event_key(key[1]), .o_event_break(brk[1]), .o_event_valid(ev[1]),
    .i_event_ready(rdy[1]), .o_modifiers(mods[1]), .o_overflow(ovf[1]),
    .i_clear_overflow(clr), .o_count(cnt_b));

  ps2_key_event_queue #(.DEPTH(8), .REPORT_BREAK(1'b0), .REPEAT_FILTER(1'b0)) u_c (
    .i_clk(clk), .i_rst(rst), .i_byte_data(bd), .i_byte_valid(bv),
    .o_event_key(key[2]), .o_event_break(brk[2]), .o_event_valid(ev[2]),
    .i_event_ready(rdy[2]), .o_modifiers(mods[2]), .o_overflow(ovf[2]),
    .i_clear_overflow(clr), .o_count(cnt_c));

  int n_cmp  = 0;
  int n_fail = 0;

  int m_depth [3] = '{8, 4, 8};
  bit m_rb    [3] = '{1'b1, 1'b1, 1'b0};
  bit m_rf    [3] = '{1'b0, 1'b1, 1'b0};
  bit         m_ext   [3];
  bit         m_brk   [3];
  int         m_skip  [3];
  bit [5:0]   m_flag  [3];
  logic [8:0] m_last  [3];
  bit         m_lastv [3];
  logic [9:0] m_q     [3][8];
  int         m_head  [3];
  int         m_cnt   [3];
  bit         m_ovf   [3];

  function automatic logic [8:0] mod_code(int i);
    case (i)
      0: return 9'h012;
      1: return 9'h059;
      2: return 9'h014;
      3: return 9'h114;
      4: return 9'h011;
      default: return 9'h111;
    endcase
  endfunction

  task automatic chk(string tag, int k, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d: observed %0h expected %0h", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset(int k);
    m_ext[k] = 0; m_brk[k] = 0; m_skip[k] = 0; m_flag[k] = '0;
    m_last[k] = '0; m_lastv[k] = 0; m_head[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0;
  endtask

  task automatic model_step(int k, logic [7:0] b, bit v, bit r, bit c);
    bit have = 0, kb = 0, pause = 0, drop = 0, push = 0, pop, acc;
    logic [8:0] kk = '0;
    if (v) begin
      if (m_skip[k] > 0) m_skip[k]--;
      else begin
        case (b)
          8'hE0: begin m_ext[k] = 1; m_brk[k] = 0; end
          8'hF0: m_brk[k] = 1;
          8'hE1: begin
            m_skip[k] = 7; have = 1; kk = 9'h1E1; pause = 1;
            m_ext[k] = 0; m_brk[k] = 0;
          end
          8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hFE, 8'hEE: begin m_ext[k] = 0; m_brk[k] = 0; end
          default: begin
            have = 1; kk = {m_ext[k], b}; kb = m_brk[k];
            m_ext[k] = 0; m_brk[k] = 0;
          end
        endcase
      end
    end
    if (have && kk != 9'h112 && kk != 9'h159) begin
      for (int i = 0; i < 6; i++) if (kk == mod_code(i)) m_flag[k][i] = !kb;
      if (!kb) begin
        if (m_rf[k] && m_lastv[k] && kk == m_last[k] && !pause) drop = 1;
        m_last[k] = kk; m_lastv[k] = 1;
      end else if (kk == m_last[k]) m_lastv[k] = 0;
      push = !drop && (!kb || m_rb[k]);
    end
    pop = r && (m_cnt[k] > 0);
    acc = push && (m_cnt[k] < m_depth[k] || pop);
    if (pop) begin m_head[k] = (m_head[k] + 1) % 8; m_cnt[k]--; end
    if (acc) begin m_q[k][(m_head[k] + m_cnt[k]) % 8] = {kb, kk}; m_cnt[k]++; end
    if (push && !acc) m_ovf[k] = 1;
    else if (c) m_ovf[k] = 0;
  endtask

  task automatic check_all(bit in_rst);
    logic [3:0] obs_cnt;
    logic [2:0] exp_mods;
    for (int k = 0; k < 3; k++) begin
      obs_cnt  = (k == 0) ? cnt_a : (k == 1) ? {1'b0, cnt_b} : cnt_c;
      exp_mods = {m_flag[k][4] | m_flag[k][5], m_flag[k][2] | m_flag[k][3],
                  m_flag[k][0] | m_flag[k][1]};
      chk("count", k, 32'(obs_cnt), 32'(m_cnt[k]));
      chk("valid", k, 32'(ev[k]), 32'(m_cnt[k] > 0));
      chk("mods", k, 32'(mods[k]), 32'(exp_mods));
      chk("overflow", k, 32'(ovf[k]), 32'(m_ovf[k]));
      if (m_cnt[k] > 0) begin
        chk("head_key", k, 32'(key[k]), 32'(m_q[k][m_head[k]][8:0]));
        chk("head_brk", k, 32'(brk[k]), 32'(m_q[k][m_head[k]][9]));
      end
      if (in_rst) begin
        chk("rst_key", k, 32'(key[k]), 32'h0);
        chk("rst_brk", k, 32'(brk[k]), 32'h0);
      end
    end
  endtask

  task automatic cyc(logic [7:0] b, bit v, logic [2:0] r, bit c, bit rs);
    bd = b; bv = v; rdy = r; clr = c; rst = rs;
    for (int k = 0; k < 3; k++) begin
      if (rs) model_reset(k);
      else model_step(k, b, v, r[k], c);
    end
    @(posedge clk);
    #1;
    check_all(rs);
  endtask

  task automatic send(logic [7:0] b, logic [2:0] r);
    cyc(b, 1'b1, r, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 8; i++) cyc(8'h00, 1'b0, 3'b111, 1'b0, 1'b0);
  endtask

  logic [7:0] pool [14] = '{8'h1C, 8'hF0, 8'hE0, 8'hE1, 8'h12, 8'h59, 8'h14,
                            8'h11, 8'h77, 8'h00, 8'hAA, 8'h1D, 8'h7C, 8'hFE};
  logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
  logic [7:0] ovf_seq [5] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
  logic [7:0] rep_seq [6] = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};
  logic [7:0] fill_seq [4] = '{8'h35, 8'h3C, 8'h43, 8'h44};

  initial begin
    bd = '0; bv = 0; rdy = '0; clr = 0; rst = 1;
    cyc(8'h00, 1'b0, 3'b000, 1'b0, 1'b1);
    cyc(8'h00, 1'b0, 3'b000, 1'b0, 1'b1);

    // Plain make then break
    send(8'h1C, 3'b000);
    chk("plain_make_key", 0, 32'(key[0]), 32'h01C);
    chk("plain_make_brk", 0, 32'(brk[0]), 32'h0);
    send(8'hF0, 3'b000);
    send(8'h1C, 3'b000);
    chk("plain_count", 0, 32'(cnt_a), 32'd2);
    cyc(8'h00, 1'b0, 3'b001, 1'b0, 1'b0);
    chk("plain_break_key", 0, 32'(key[0]), 32'h01C);
    chk("plain_break_brk", 0, 32'(brk[0]), 32'h1);
    drain();

    // Extended right ctrl with break reporting off; fake shift dropped
    send(8'hE0, 3'b000);
    send(8'h14, 3'b000);
    chk("ext_key", 2, 32'(key[2]), 32'h114);
    chk("ext_mods", 2, 32'(mods[2]), 32'b010);
    send(8'hE0, 3'b000);
    send(8'hF0, 3'b000);
    send(8'h14, 3'b000);
    chk("ext_brk_mods", 2, 32'(mods[2]), 32'b000);
    chk("ext_brk_count", 2, 32'(cnt_c), 32'd1);
    send(8'hE0, 3'b000);
    send(8'h12, 3'b000);
    chk("fake_shift_count", 2, 32'(cnt_c), 32'd1);
    drain();

    // Pause sequence yields a single event
    for (int i = 0; i < 8; i++) send(pause_seq[i], 3'b000);
    send(8'h1C, 3'b000);
    chk("pause_count", 0, 32'(cnt_a), 32'd2);
    chk("pause_key", 0, 32'(key[0]), 32'h1E1);
    cyc(8'h00, 1'b0, 3'b001, 1'b0, 1'b0);
    chk("after_pause_key", 0, 32'(key[0]), 32'h01C);
    drain();

    // Overflow on the four-entry queue
    for (int i = 0; i < 5; i++) send(ovf_seq[i], 3'b000);
    chk("ovf_count", 1, 32'(cnt_b), 32'd4);
    chk("ovf_flag", 1, 32'(ovf[1]), 32'h1);
    chk("ovf_head", 1, 32'(key[1]), 32'h015);
    for (int i = 0; i < 4; i++) cyc(8'h00, 1'b0, 3'b010, 1'b0, 1'b0);
    cyc(8'h00, 1'b0, 3'b000, 1'b1, 1'b0);
    chk("ovf_cleared", 1, 32'(ovf[1]), 32'h0);
    for (int i = 0; i < 4; i++) send(fill_seq[i], 3'b000);
    send(8'h4B, 3'b010);
    chk("full_pushpop_count", 1, 32'(cnt_b), 32'd4);
    chk("full_pushpop_ovf", 1, 32'(ovf[1]), 32'h0);
    chk("full_pushpop_head", 1, 32'(key[1]), 32'h03C);
    drain();
    cyc(8'h00, 1'b0, 3'b000, 1'b1, 1'b0);

    // Typematic repeat filter
    for (int i = 0; i < 6; i++) send(rep_seq[i], 3'b000);
    chk("repeat_count", 1, 32'(cnt_b), 32'd3);
    drain();

    // Reset discards a pending prefix
    send(8'hE0, 3'b000);
    send(8'hF0, 3'b000);
    cyc(8'h00, 1'b0, 3'b000, 1'b0, 1'b1);
    send(8'h75, 3'b000);
    chk("post_rst_key", 0, 32'(key[0]), 32'h075);
    chk("post_rst_brk", 0, 32'(brk[0]), 32'h0);

    for (int n = 0; n < 3000; n++) begin
      cyc(pool[$urandom_range(0, 13)], ($urandom_range(0, 3) != 0), 3'($urandom),
          ($urandom_range(0, 19) == 0), ($urandom_range(0, 499) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
